// File: rtl/retire_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : retire_pkg
//  Purpose  : Shared retire-entry layout and packing helper for the retire
//             trace buffer and its FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package retire_pkg;

  // Retire entry layout: {rf_en, rf_waddr[4:0], rf_wdata[31:0], pc[31:0]}
  localparam int RETIRE_W     = 70;
  localparam int RT_PC_LSB    = 0;
  localparam int RT_WDATA_LSB = 32;
  localparam int RT_WADDR_LSB = 64;
  localparam int RT_EN_BIT    = 69;

  // Build one retire entry from its fields.
  function automatic logic [RETIRE_W-1:0] pack_retire(
    input logic        en,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic [31:0] pc
  );
    logic [RETIRE_W-1:0] e;
    e                         = '0;
    e[RT_EN_BIT]              = en;
    e[RT_WADDR_LSB +: 5]      = waddr;
    e[RT_WDATA_LSB +: 32]     = wdata;
    e[RT_PC_LSB    +: 32]     = pc;
    return e;
  endfunction

  // A register-file write is only architecturally visible when it targets
  // something other than x0.
  function automatic logic rf_write_visible(
    input logic       wen,
    input logic [4:0] waddr
  );
    return wen & (waddr != 5'd0);
  endfunction

endpackage : retire_pkg
`default_nettype wire

// File: rtl/retire_fifo_2w1r.sv
`default_nettype none
// ============================================================================
//  Module   : retire_fifo_2w1r
//  Purpose  : Circular buffer with two write ports (program-ordered) and one
//             read port. Tracks occupancy in its own register.
//  Revision : 1.0  initial release
// ============================================================================
module retire_fifo_2w1r
  import retire_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = RETIRE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en0,
  input  logic [WIDTH-1:0]           wr_data0,
  input  logic                       wr_en1,
  input  logic [WIDTH-1:0]           wr_data1,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      wptr_p1;
  logic [1:0]       n_push;
  logic             do_pop;
  logic [AW-1:0]    lane1_idx;

  assign wptr_p1   = wptr + {{AW{1'b0}}, 1'b1};
  assign n_push    = {1'b0, wr_en0} + {1'b0, wr_en1};
  assign do_pop    = rd_en & ~empty;
  // Lane1 lands directly behind lane0 when both write, else at the tail.
  assign lane1_idx = wr_en0 ? wptr_p1[AW-1:0] : wptr[AW-1:0];

  assign full      = (occupancy == FULL_OCC);
  assign empty     = (occupancy == '0);
  // Head is read from storage as it stood before this edge's writes.
  assign rd_data   = mem[rptr[AW-1:0]];

  // Storage writes; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wptr[AW-1:0]] <= wr_data0;
    if (wr_en1) mem[lane1_idx]    <= wr_data1;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      wptr      <= wptr + {{(AW-1){1'b0}}, n_push};
      rptr      <= rptr + {{AW{1'b0}}, do_pop};
      occupancy <= occupancy + {{(AW-1){1'b0}}, n_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule : retire_fifo_2w1r
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : retire_trace_buffer
//  Purpose  : Collects up to two retiring instructions per cycle and emits
//             them one per cycle, in program order, on inst_retire. Counts
//             emitted instructions and flags pushes made while not ready.
//  Revision : 1.0  initial release
// ============================================================================
module retire_trace_buffer
  import retire_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                wb_valid0,
  input  logic [31:0]         wb_pc0,
  input  logic                wb_rf_wen0,
  input  logic [4:0]          wb_rf_waddr0,
  input  logic [31:0]         wb_rf_wdata0,
  input  logic                wb_valid1,
  input  logic [31:0]         wb_pc1,
  input  logic                wb_rf_wen1,
  input  logic [4:0]          wb_rf_waddr1,
  input  logic [31:0]         wb_rf_wdata1,
  output logic                wb_ready,
  output logic [RETIRE_W-1:0] inst_retire,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic                overflow_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] LAST_FREE = (AW+1)'(DEPTH - 1);

  logic [RETIRE_W-1:0] entry0;
  logic [RETIRE_W-1:0] entry1;
  logic [RETIRE_W-1:0] head;
  logic [AW:0]         occupancy;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push0;
  logic                push1;
  logic                pop;
  logic                push_rejected;

  // Ready only with two free slots, so a dual retire can always be taken
  // whole; a single free slot is deliberately treated as not ready.
  assign wb_ready      = ~fifo_full & (occupancy != LAST_FREE);

  assign push0         = wb_valid0 & wb_ready;
  assign push1         = wb_valid1 & wb_ready;
  assign pop           = ~fifo_empty;
  assign push_rejected = (wb_valid0 | wb_valid1) & ~wb_ready;

  // x0 writes are still queued (to keep the PC stream gap-free) but are
  // marked as not writing the register file.
  assign entry0 = pack_retire(rf_write_visible(wb_rf_wen0, wb_rf_waddr0),
                              wb_rf_waddr0, wb_rf_wdata0, wb_pc0);
  assign entry1 = pack_retire(rf_write_visible(wb_rf_wen1, wb_rf_waddr1),
                              wb_rf_waddr1, wb_rf_wdata1, wb_pc1);

  retire_fifo_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (RETIRE_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_reset_n),
    .wr_en0    (push0),
    .wr_data0  (entry0),
    .wr_en1    (push1),
    .wr_data1  (entry1),
    .rd_en     (pop),
    .rd_data   (head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output register: one popped entry per cycle, zero when nothing to emit.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      inst_retire <= '0;
    end else if (pop) begin
      inst_retire <= head;
    end else begin
      inst_retire <= '0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      retired_cnt <= '0;
    end else if (pop) begin
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      overflow_err <= 1'b0;
    end else if (push_rejected) begin
      overflow_err <= 1'b1;
    end
  end

endmodule : retire_trace_buffer
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retire_trace_buffer
//  Purpose  : Self-checking bench for retire_trace_buffer using a queue-based
//             reference model of the retire stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        wb_valid0, wb_rf_wen0, wb_valid1, wb_rf_wen1;
  logic [31:0] wb_pc0, wb_rf_wdata0, wb_pc1, wb_rf_wdata1;
  logic [4:0]  wb_rf_waddr0, wb_rf_waddr1;
  logic        wb_ready;
  logic [69:0] inst_retire;
  logic [CNT_W-1:0] retired_cnt;
  logic        overflow_err;

  always #5 sys_clk = ~sys_clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .wb_valid0    (wb_valid0),
    .wb_pc0       (wb_pc0),
    .wb_rf_wen0   (wb_rf_wen0),
    .wb_rf_waddr0 (wb_rf_waddr0),
    .wb_rf_wdata0 (wb_rf_wdata0),
    .wb_valid1    (wb_valid1),
    .wb_pc1       (wb_pc1),
    .wb_rf_wen1   (wb_rf_wen1),
    .wb_rf_waddr1 (wb_rf_waddr1),
    .wb_rf_wdata1 (wb_rf_wdata1),
    .wb_ready     (wb_ready),
    .inst_retire  (inst_retire),
    .retired_cnt  (retired_cnt),
    .overflow_err (overflow_err)
  );

  // Reference model state
  logic [69:0] q[$];
  logic [69:0] exp_retire;
  logic [31:0] exp_cnt;
  logic        exp_ovf;
  logic        last_popped;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] mk(input logic wen, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic [31:0] pc);
    logic en;
    en = wen && (wa != 5'd0);
    return {en, wa, wd, pc};
  endfunction

  function automatic logic model_ready();
    return (q.size() <= DEPTH - 2);
  endfunction

  task automatic model_reset();
    q.delete();
    exp_retire  = '0;
    exp_cnt     = '0;
    exp_ovf     = 1'b0;
    last_popped = 1'b0;
  endtask

  task automatic set_lane0(input logic [31:0] pc, input logic wen,
                           input logic [4:0] wa, input logic [31:0] wd);
    wb_valid0 = 1'b1; wb_pc0 = pc; wb_rf_wen0 = wen; wb_rf_waddr0 = wa; wb_rf_wdata0 = wd;
  endtask

  task automatic set_lane1(input logic [31:0] pc, input logic wen,
                           input logic [4:0] wa, input logic [31:0] wd);
    wb_valid1 = 1'b1; wb_pc1 = pc; wb_rf_wen1 = wen; wb_rf_waddr1 = wa; wb_rf_wdata1 = wd;
  endtask

  // One clock cycle: check ready, advance the model at the edge, check outputs.
  task automatic step();
    logic rdy;
    rdy = model_ready();
    chk("wb_ready", {69'd0, wb_ready}, {69'd0, rdy});
    @(posedge sys_clk);
    last_popped = (q.size() > 0);
    if (last_popped) begin
      exp_retire = q.pop_front();
      exp_cnt    = exp_cnt + 1;
    end else begin
      exp_retire = '0;
    end
    if (rdy) begin
      if (wb_valid0) q.push_back(mk(wb_rf_wen0, wb_rf_waddr0, wb_rf_wdata0, wb_pc0));
      if (wb_valid1) q.push_back(mk(wb_rf_wen1, wb_rf_waddr1, wb_rf_wdata1, wb_pc1));
    end else if (wb_valid0 || wb_valid1) begin
      exp_ovf = 1'b1;
    end
    #1;
    chk("inst_retire", inst_retire, exp_retire);
    chk("retired_cnt", {38'd0, retired_cnt}, {38'd0, exp_cnt});
    chk("overflow_err", {69'd0, overflow_err}, {69'd0, exp_ovf});
    wb_valid0 = 1'b0;
    wb_valid1 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step();
    chk("drained", {69'd0, (q.size() == 0)}, 70'd1);
  endtask

  initial begin
    logic [31:0] next_in, next_out;
    int          emitted, first_drop_occ;
    logic        saw_stall;

    sys_reset_n = 1'b0;
    wb_valid0 = 0; wb_pc0 = 0; wb_rf_wen0 = 0; wb_rf_waddr0 = 0; wb_rf_wdata0 = 0;
    wb_valid1 = 0; wb_pc1 = 0; wb_rf_wen1 = 0; wb_rf_waddr1 = 0; wb_rf_wdata1 = 0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;

    // Reset then idle
    repeat (10) step();
    chk("idle_ready", {69'd0, wb_ready}, 70'd1);

    // Single lane0 push
    set_lane0(32'hBFC00000, 1'b1, 5'd5, 32'h12345678);
    step();
    step();
    chk("single_entry", inst_retire, 70'h25_12345678_BFC00000);
    chk("single_cnt", {38'd0, retired_cnt}, 70'd1);
    step();
    chk("single_then_zero", inst_retire, 70'd0);

    // Dual push, lane1 targets x0
    set_lane0(32'h100, 1'b1, 5'd3, 32'hA);
    set_lane1(32'h104, 1'b1, 5'd0, 32'hB);
    step();
    step();
    chk("dual_pc0", {38'd0, inst_retire[31:0]}, 70'h100);
    chk("dual_en0", {69'd0, inst_retire[69]}, 70'd1);
    step();
    chk("dual_pc1", {38'd0, inst_retire[31:0]}, 70'h104);
    chk("dual_en1", {69'd0, inst_retire[69]}, 70'd0);
    step();

    // Sustained dual retire; upstream honours wb_ready
    next_in = 0; next_out = 0; emitted = 0; saw_stall = 0; first_drop_occ = -1;
    for (int cyc = 0; cyc < 400 && emitted < 100; cyc++) begin
      if (!wb_ready && !saw_stall) begin
        saw_stall = 1'b1;
        first_drop_occ = q.size();
      end
      if (wb_ready && next_in < 32'd400) begin
        set_lane0(next_in,     1'b1, 5'($urandom_range(1, 31)), $urandom);
        set_lane1(next_in + 4, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        next_in = next_in + 8;
      end
      step();
      if (last_popped) begin
        chk("seq_pc", {38'd0, inst_retire[31:0]}, {38'd0, next_out});
        next_out = next_out + 4;
        emitted++;
      end
    end
    chk("sustain_done", {69'd0, (emitted >= 100)}, 70'd1);
    chk("stall_seen", {69'd0, saw_stall}, 70'd1);
    chk("stall_occ", 70'(first_drop_occ), 70'(DEPTH - 1));
    chk("no_ovf_sustain", {69'd0, overflow_err}, 70'd0);
    drain();

    // Overflow: fill, then push while not ready
    for (int i = 0; i < 20 && wb_ready; i++) begin
      set_lane0(32'h2000 + 32'(i * 8), 1'b1, 5'd7, $urandom);
      set_lane1(32'h2004 + 32'(i * 8), 1'b1, 5'd8, $urandom);
      step();
    end
    chk("full_not_ready", {69'd0, wb_ready}, 70'd0);
    set_lane0(32'hDEAD0000, 1'b1, 5'd9, 32'hDEADBEEF);
    set_lane1(32'hDEAD0004, 1'b1, 5'd9, 32'hDEADBEEF);
    step();
    chk("ovf_set", {69'd0, overflow_err}, 70'd1);
    drain();
    step();
    chk("ovf_sticky", {69'd0, overflow_err}, 70'd1);

    // Random traffic, lanes independently valid, ready not always honoured
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0)
        set_lane0($urandom, 1'($urandom), 5'($urandom), $urandom);
      if ($urandom_range(0, 2) != 0)
        set_lane1($urandom, 1'($urandom), 5'($urandom), $urandom);
      step();
    end
    drain();

    // Async reset with five entries queued
    for (int i = 0; i < 4; i++) begin
      set_lane0(32'h3000 + 32'(i * 8), 1'b1, 5'd1, $urandom);
      set_lane1(32'h3004 + 32'(i * 8), 1'b1, 5'd2, $urandom);
      step();
    end
    #2;
    sys_reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_retire", inst_retire, 70'd0);
    chk("arst_ready", {69'd0, wb_ready}, 70'd1);
    chk("arst_cnt", {38'd0, retired_cnt}, 70'd0);
    chk("arst_ovf", {69'd0, overflow_err}, 70'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    repeat (6) step();
    chk("post_reset_idle", inst_retire, 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_retire_trace_buffer
`default_nettype wire
